bp_be_dcache_trace_driver: RTL
==============================

# bp_be_dcache_trace_driver

Parametrised trace-replay stimulus and response-checker engine for cache-subsystem benches. It sits between a combinational trace ROM and a device under test such as the dcache wrapper. It replaces the fixed single-entry output buffer and hard-coded start-up delay with a configurable start-up delay, a response FIFO of configurable depth, a timed-wait opcode, a saturating mismatch counter and a progress watchdog. It is synthesizable; only the ROM contents are bench-specific.

## Interface
Parameters:
- payload_width_p, 128, width of the packet driven to the DUT.
- data_width_p, 64, response width; must be ≤ payload_width_p.
- rom_addr_width_p, 8, trace ROM address width.
- init_delay_p, 65, cycles after reset before the first ROM entry executes (≥1).
- fifo_els_p, 2, response FIFO depth (≥1).
- timeout_p, 65535, watchdog limit in cycles without progress (≥1).

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- reset_i  in  1  reset; asynchronous and active-high.
- rom_addr_o  out  rom_addr_width_p  current trace entry address.
- rom_data_i  in  payload_width_p+4  entry, {op[3:0], payload}.
- pkt_v_o  out  1  packet valid.
- pkt_o  out  payload_width_p  packet; equals rom_data_i payload.
- pkt_ready_i  in  1  DUT accepts the packet.
- resp_v_i  in  1  response valid.
- resp_i  in  data_width_p  response data.
- resp_ready_o  out  1  FIFO not full.
- done_o  out  1  DONE opcode reached; sticky.
- error_o  out  1  any mismatch, illegal opcode or timeout; sticky.
- error_count_o  out  16  mismatch and illegal-opcode count; saturates at 16'hFFFF.
- timeout_o  out  1  watchdog fired; sticky.

## Operation
States and transitions:
- e_init: counts init_delay_p cycles, then moves to e_run.
- e_run: executes the entry at rom_addr_o.
- e_wait: counts down a WAIT length.
- e_done: terminal.
- e_timeout: terminal.

Opcodes in e_run (an opcode "retires" when it completes):
- 4'h1 SEND: pkt_v_o=1. Retires when pkt_ready_i=1.
- 4'h2 RECV: retires when the FIFO is non-empty. On retire it pops the head and compares it to payload[data_width_p-1:0]. On mismatch, error_count_o increments and error_o sets.
- 4'h3 DONE: moves to e_done and sets done_o. rom_addr_o holds its value.
- 4'h4 WAIT: loads the wait counter with payload[15:0] and moves to e_wait. In e_wait the counter decrements each cycle. When it reads 0, the entry retires and the block returns to e_run. A WAIT of n occupies n+1 cycles.
- Any other opcode: illegal. It retires in one cycle, increments error_count_o and sets error_o.

Retire and FIFO rules:
- On retire, rom_addr_o increments modulo 2^rom_addr_width_p; wrap-around is legal.
- Responses are enqueued when resp_v_i & resp_ready_o, in every state including e_init, e_done and e_timeout.
- When the FIFO is full, resp_ready_o=0. There is no enqueue-while-full even if a dequeue happens in the same cycle.
- Simultaneous enqueue and dequeue on a non-empty, non-full FIFO is allowed, and the occupancy stays the same.

## Timing
- Reset values of outputs: rom_addr_o=0, pkt_v_o=0, resp_ready_o=1 (FIFO empty), done_o=0, error_o=0, error_count_o=0, timeout_o=0.
- Reset values of internal state: state=e_init, delay, wait and watchdog counters at 0.
- Reset asserted mid-operation returns every register to its reset value immediately. FIFO contents are discarded.
- pkt_v_o and pkt_o are combinational from state and rom_data_i. The ROM has zero latency.
- A SEND with pkt_ready_i already high retires in 1 cycle, giving one packet per cycle back-to-back.
- Enqueued data is visible to RECV in the following cycle; there is no bypass. Minimum response-to-retire latency is 1 cycle.
- pkt_v_o=0 in e_init, e_wait, e_done and e_timeout.
- The mismatch and illegal-opcode count increments once per cycle at most and holds at 16'hFFFF.

## Configuration
Macro BP_TRACE_DRIVER_WATCHDOG_EN.
- Defined: the watchdog counter increments each cycle in e_run and e_wait. It clears on any retire and during a WAIT countdown decrement. When it reaches timeout_p, the block moves to e_timeout and sets timeout_o=1 and error_o=1. error_count_o does not change.
- Not defined: there is no watchdog logic, timeout_o is tied to 0 and e_timeout is unreachable.

## Test plan
- Reset, init_delay_p=65, ROM[0]=SEND 0xAB, pkt_ready_i=1 → pkt_v_o first high 65 cycles after reset deasserts; rom_addr_o=1 the next cycle.
- SEND 0x10, RECV 0x10, RECV 0x99, DONE; DUT returns 0x10 then 0x55 → error_count_o=1, error_o=1, done_o=1, rom_addr_o held at 3.
- fifo_els_p=2, three back-to-back resp_v_i while the engine executes WAIT 10 → resp_ready_o drops after the second; the third is held by the source and enqueued once the first RECV pops.
- WAIT 0 then WAIT 5 → e_wait occupies 1 cycle and then 6 cycles; pkt_v_o stays 0 throughout.
- With the watchdog enabled and timeout_p=100, SEND with pkt_ready_i stuck at 0 → timeout_o=1 after 100 cycles and state stays in e_timeout; with the macro off, no timeout ever fires.
- Opcode 4'hF at address 255 → error_count_o increments and rom_addr_o wraps to 0; asynchronous reset asserted mid-WAIT clears all outputs the same cycle.

Source files
------------

// File: rtl/bp_be_dcache_trace_driver.sv
// ---------------------------------------------------------------------------
// bp_be_dcache_trace_driver
//
// Trace-replay stimulus / response-checker engine.
//
// A combinational trace ROM supplies one entry at a time. Each entry is
// {op[3:0], payload}. The engine drives packets to a DUT, queues the DUT's
// responses in a small FIFO and compares them against expected values from
// the trace. It flags mismatches and illegal opcodes, and it can optionally
// stop on a progress watchdog.
//
// Ports
//   clk_i, reset_i   clock; asynchronous active-high reset
//   rom_addr_o       address of the current trace entry
//   rom_data_i       trace entry {op, payload}, zero-latency ROM
//   pkt_v_o / pkt_o  packet to the DUT (valid only while executing a SEND)
//   pkt_ready_i      the DUT accepts the packet
//   resp_v_i/resp_i  response from the DUT, enqueued when resp_ready_o is high
//   resp_ready_o     response FIFO is not full
//   done_o           sticky; the DONE opcode was reached
//   error_o          sticky; a mismatch, an illegal opcode or a timeout occurred
//   error_count_o    saturating count of mismatches and illegal opcodes
//   timeout_o        sticky; the watchdog fired
//
// Optional feature: define BP_TRACE_DRIVER_WATCHDOG_EN to enable the
// progress watchdog. Without the macro, timeout_o is tied to 0.
// ---------------------------------------------------------------------------
module bp_be_dcache_trace_driver #(
    parameter int payload_width_p  = 128,
    parameter int data_width_p     = 64,
    parameter int rom_addr_width_p = 8,
    parameter int init_delay_p     = 65,
    parameter int fifo_els_p       = 2,
    parameter int timeout_p        = 65535
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    output logic [rom_addr_width_p-1:0] rom_addr_o,
    input  logic [payload_width_p+3:0]  rom_data_i,
    output logic                        pkt_v_o,
    output logic [payload_width_p-1:0]  pkt_o,
    input  logic                        pkt_ready_i,
    input  logic                        resp_v_i,
    input  logic [data_width_p-1:0]     resp_i,
    output logic                        resp_ready_o,
    output logic                        done_o,
    output logic                        error_o,
    output logic [15:0]                 error_count_o,
    output logic                        timeout_o
);

    // The delay counter only needs to reach init_delay_p-1.
    localparam int dly_w_lp = (init_delay_p > 1) ? $clog2(init_delay_p) : 1;
    localparam int ptr_w_lp = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
    localparam int cnt_w_lp = $clog2(fifo_els_p + 1);

    localparam logic [3:0] op_send_lp = 4'h1;
    localparam logic [3:0] op_recv_lp = 4'h2;
    localparam logic [3:0] op_done_lp = 4'h3;
    localparam logic [3:0] op_wait_lp = 4'h4;

    typedef enum logic [2:0] {
        e_init    = 3'd0,
        e_run     = 3'd1,
        e_wait    = 3'd2,
        e_done    = 3'd3,
        e_timeout = 3'd4
    } state_e;

    state_e                        state_q, state_d;
    logic [rom_addr_width_p-1:0]   addr_q, addr_d;
    logic [dly_w_lp-1:0]           delay_q, delay_d;
    logic [15:0]                   wait_q, wait_d;
    logic                          done_q, done_d;
    logic                          error_q, error_d;
    logic [15:0]                   err_cnt_q, err_cnt_d;

    logic [data_width_p-1:0]       mem_q [fifo_els_p];
    logic [data_width_p-1:0]       mem_d [fifo_els_p];
    logic [ptr_w_lp-1:0]           rd_ptr_q, rd_ptr_d;
    logic [ptr_w_lp-1:0]           wr_ptr_q, wr_ptr_d;
    logic [cnt_w_lp-1:0]           count_q, count_d;

`ifdef BP_TRACE_DRIVER_WATCHDOG_EN
    localparam int wd_w_lp = (timeout_p > 1) ? $clog2(timeout_p) : 1;
    logic [wd_w_lp-1:0]            wd_q, wd_d;
    logic                          timeout_q, timeout_d;
`endif

    logic [3:0]                    op_s;
    logic [payload_width_p-1:0]    payload_s;
    logic                          full_s;
    logic                          empty_s;
    logic                          enq_s;
    logic                          deq_s;
    logic                          retire_s;
    logic                          bump_s;

    // Circular-buffer pointer advance; the depth need not be a power of two.
    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        if (p == ptr_w_lp'(fifo_els_p - 1)) begin
            return '0;
        end else begin
            return p + ptr_w_lp'(1);
        end
    endfunction

    assign op_s      = rom_data_i[payload_width_p +: 4];
    assign payload_s = rom_data_i[payload_width_p-1:0];
    assign full_s    = (count_q == cnt_w_lp'(fifo_els_p));
    assign empty_s   = (count_q == '0);
    // A full FIFO refuses data even when a pop happens in the same cycle.
    assign enq_s     = resp_v_i & ~full_s;

    assign rom_addr_o    = addr_q;
    assign pkt_o         = payload_s;
    assign pkt_v_o       = (state_q == e_run) && (op_s == op_send_lp);
    assign resp_ready_o  = ~full_s;
    assign done_o        = done_q;
    assign error_o       = error_q;
    assign error_count_o = err_cnt_q;
`ifdef BP_TRACE_DRIVER_WATCHDOG_EN
    assign timeout_o     = timeout_q;
`else
    assign timeout_o     = 1'b0;
`endif

    // Sequencer: trace execution, retire, error accounting and watchdog.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        delay_d   = delay_q;
        wait_d    = wait_q;
        done_d    = done_q;
        error_d   = error_q;
        err_cnt_d = err_cnt_q;
        retire_s  = 1'b0;
        deq_s     = 1'b0;
        bump_s    = 1'b0;
`ifdef BP_TRACE_DRIVER_WATCHDOG_EN
        wd_d      = wd_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            e_init: begin
                if (delay_q == dly_w_lp'(init_delay_p - 1)) begin
                    state_d = e_run;
                end else begin
                    delay_d = delay_q + dly_w_lp'(1);
                end
            end
            e_run: begin
                case (op_s)
                    op_send_lp: begin
                        retire_s = pkt_ready_i;
                    end
                    op_recv_lp: begin
                        if (!empty_s) begin
                            retire_s = 1'b1;
                            deq_s    = 1'b1;
                            bump_s   = (mem_q[rd_ptr_q] != payload_s[data_width_p-1:0]);
                        end else begin
                            retire_s = 1'b0;
                        end
                    end
                    op_done_lp: begin
                        state_d = e_done;
                        done_d  = 1'b1;
                    end
                    op_wait_lp: begin
                        wait_d  = payload_s[15:0];
                        state_d = e_wait;
                    end
                    default: begin
                        retire_s = 1'b1;
                        bump_s   = 1'b1;
                    end
                endcase
            end
            e_wait: begin
                // The cycle in which the counter reads zero is the retire cycle.
                if (wait_q == 16'd0) begin
                    retire_s = 1'b1;
                    state_d  = e_run;
                end else begin
                    wait_d = wait_q - 16'd1;
                end
            end
            e_done: begin
                state_d = e_done;
            end
            e_timeout: begin
                state_d = e_timeout;
            end
            default: begin
                state_d = e_init;
            end
        endcase

        if (retire_s) begin
            addr_d = addr_q + rom_addr_width_p'(1);
        end else begin
            addr_d = addr_q;
        end

        if (bump_s) begin
            error_d = 1'b1;
            if (err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end else begin
                err_cnt_d = err_cnt_q;
            end
        end else begin
            err_cnt_d = err_cnt_q;
        end

`ifdef BP_TRACE_DRIVER_WATCHDOG_EN
        // Every e_wait cycle either decrements or retires, so it always counts as progress.
        if ((state_q == e_run) || (state_q == e_wait)) begin
            if (retire_s || (state_q == e_wait)) begin
                wd_d = '0;
            end else if ((wd_q == wd_w_lp'(timeout_p - 1)) && (state_d == state_q)) begin
                wd_d      = '0;
                state_d   = e_timeout;
                timeout_d = 1'b1;
                error_d   = 1'b1;
            end else begin
                wd_d = wd_q + wd_w_lp'(1);
            end
        end else begin
            wd_d = wd_q;
        end
`endif
    end

    // Response FIFO next state: push on enqueue, pop on a RECV retire.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq_s) begin
            mem_d[wr_ptr_q] = resp_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (deq_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({enq_s, deq_s})
            2'b10:   count_d = count_q + cnt_w_lp'(1);
            2'b01:   count_d = count_q - cnt_w_lp'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards the FIFO contents and all sticky flags.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= e_init;
            addr_q    <= '0;
            delay_q   <= '0;
            wait_q    <= 16'd0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            err_cnt_q <= 16'd0;
            mem_q     <= '{default: '0};
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
`ifdef BP_TRACE_DRIVER_WATCHDOG_EN
            wd_q      <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            delay_q   <= delay_d;
            wait_q    <= wait_d;
            done_q    <= done_d;
            error_q   <= error_d;
            err_cnt_q <= err_cnt_d;
            mem_q     <= mem_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
`ifdef BP_TRACE_DRIVER_WATCHDOG_EN
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
`endif
        end
    end

endmodule
